// File: rtl/mips_cpu_mult_div.sv
// mips_cpu_mult_div
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   Supports MULT, MULTU, DIV, DIVU (one bit per clock, WIDTH iterations plus
//   one sign-fix cycle) and the MTHI/MTLO register writes.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-low
//   start        launch op (accepted only in IDLE)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a    rs value (multiplicand / dividend)
//   operand_b    rt value (multiplier / divisor)
//   mthi, mtlo   write hi_lo_wdata into HI / LO (IDLE, no start)
//   hi_lo_wdata  data for MTHI/MTLO
//   busy         operation in flight
//   done         one-cycle pulse, HI/LO hold the new result
//   hi, lo       architectural HI/LO registers
module mips_cpu_mult_div #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] hi_lo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, state_next;
  logic             done_next;
  logic [CW-1:0]    count;
  // acc_hi: product upper half / partial remainder
  // acc_lo: multiplier bits (shifted out) / dividend bits -> quotient
  // opd:    multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0] acc_hi, acc_lo, opd, a_raw;
  logic             neg_q, neg_r, is_div;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    sgn_op, a_neg, b_neg, div0;
  logic [WIDTH:0]          mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]      prod_fix;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x,
                                               input logic en);
    return (en && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                  input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  assign a_s    = operand_a;
  assign b_s    = operand_b;
  assign sgn_op = ~op[0];
  assign a_neg  = (a_s < 0);
  assign b_neg  = (b_s < 0);
  assign div0   = (opd == '0);

  // Shift-add step: conditionally add multiplicand into the upper half, then
  // shift the whole 2*WIDTH accumulator right by one.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
  // Restoring-divide step: bring in the next dividend bit and trial-subtract.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd};
  assign prod_fix  = cond_neg_2w({acc_hi, acc_lo}, neg_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) state_next = op[1] ? DIV : MUL;
      MUL:  if (count == LAST) state_next = FIX;
      DIV: begin
        // Divide by zero skips the iterations entirely.
        if (div0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (count == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count  <= '0;
            acc_hi <= '0;
            is_div <= op[1];
            a_raw  <= operand_a;
            neg_q  <= sgn_op & (a_neg ^ b_neg);
            neg_r  <= sgn_op & a_neg;
            if (op[1]) begin
              acc_lo <= abs_val(operand_a, sgn_op);
              opd    <= abs_val(operand_b, sgn_op);
            end else begin
              acc_lo <= abs_val(operand_b, sgn_op);
              opd    <= abs_val(operand_a, sgn_op);
            end
          end else begin
            if (mthi) hi <= hi_lo_wdata;
            if (mtlo) lo <= hi_lo_wdata;
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          count  <= count + 1'b1;
        end
        DIV: begin
          if (div0) begin
            hi <= a_raw;
            lo <= DIV0_LO;
          end else begin
            if (!div_diff[WIDTH]) begin
              acc_hi <= div_diff[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
          end
        end
        FIX: begin
          if (is_div) begin
            lo <= cond_neg_w(acc_lo, neg_q);
            hi <= cond_neg_w(acc_hi, neg_r);
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mult_div.sv
module tb_mips_cpu_mult_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        mthi, mtlo;
  logic [31:0] hi_lo_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mips_cpu_mult_div #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mthi(mthi), .mtlo(mtlo), .hi_lo_wdata(hi_lo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Drive an op and let the accept edge (E0) pass; returns 1 ns after E0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = 32'hDEAD_BEEF; operand_b = 32'h0BAD_F00D;
  endtask

  // Wait (bounded) for done; lat = edges after E0, bc = cycles busy was seen high.
  task automatic wait_done(output int lat, output int bc);
    lat = 0; bc = 0;
    while (1) begin
      if (busy) bc++;
      if (done || lat >= 100) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat, bc;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    tests++; if (lat !== 33) begin fails++; $display("FAIL multu_latency: got %0d want 33", lat); end
    tests++; if (bc !== 33) begin fails++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
    tests++; if (hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    tests++; if (lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_mult();
    int lat, bc;
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, bc);
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
    tests++; if (lo !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
    launch(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bc);
    tests++; if (hi !== 32'h4000_0000) begin fails++; $display("FAIL mult_min_hi: got %h want 40000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL mult_min_lo: got %h want 0", lo); end
  endtask

  task automatic test_div();
    int lat, bc;
    launch(2'b11, 32'd100, 32'd7);
    wait_done(lat, bc);
    tests++; if (lat !== 33) begin fails++; $display("FAIL divu_latency: got %0d want 33", lat); end
    tests++; if (lo !== 32'd14) begin fails++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    tests++; if (hi !== 32'd2) begin fails++; $display("FAIL divu_hi: got %h want 00000002", hi); end
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bc);
    tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
  endtask

  task automatic test_div0();
    int lat, bc;
    launch(2'b10, 32'd5, 32'd0);
    wait_done(lat, bc);
    tests++; if (lat !== 1) begin fails++; $display("FAIL div0_latency: got %0d want 1", lat); end
    tests++; if (hi !== 32'd5) begin fails++; $display("FAIL div0_hi: got %h want 00000005", hi); end
    tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    // Previous result: hi=5, lo=ffffffff (from divide by zero)
    launch(2'b00, 32'd6, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    op = 2'b11; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL hold_during_op: got hi=%h lo=%h want hi=00000005 lo=ffffffff", hi, lo);
    end
    wait_done(lat, bc);
    tests++; if (lat + 5 !== 33) begin fails++; $display("FAIL ignore_start_latency: got %0d want 33", lat + 5); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL ignore_start_hi: got %h want 0", hi); end
    tests++; if (lo !== 32'd42) begin fails++; $display("FAIL ignore_start_lo: got %h want 0000002a", lo); end
  endtask

  task automatic test_reset_mid();
    int seen;
    launch(2'b01, 32'hFFFF_FFFF, 32'd2);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done: got %b want 0", done); end
    tests++; if (hi !== 32'h0 || lo !== 32'h0) begin
      fails++; $display("FAIL midreset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_mt();
    int lat, bc;
    hi_lo_wdata = 32'h0000_1234; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    tests++; if (hi !== 32'h0000_1234) begin fails++; $display("FAIL mthi: got %h want 00001234", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL mthi_lo_kept: got %h want 0", lo); end
    hi_lo_wdata = 32'h0000_00AA; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    tests++; if (lo !== 32'h0000_00AA) begin fails++; $display("FAIL mtlo: got %h want 000000aa", lo); end
    // MTLO while busy is dropped
    launch(2'b01, 32'd2, 32'd3);
    hi_lo_wdata = 32'h0000_DEAD; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    tests++; if (lo !== 32'h0000_00AA) begin fails++; $display("FAIL mtlo_busy: got %h want 000000aa", lo); end
    wait_done(lat, bc);
    tests++; if (lo !== 32'd6 || hi !== 32'h0) begin
      fails++; $display("FAIL mul_after_mt: got hi=%h lo=%h want 0/00000006", hi, lo);
    end
    // start and mtlo together: start wins
    hi_lo_wdata = 32'h0000_BEEF; mtlo = 1'b1;
    launch(2'b01, 32'd5, 32'd5);
    mtlo = 1'b0;
    tests++; if (lo !== 32'd6) begin fails++; $display("FAIL start_mt_dropped: got %h want 00000006", lo); end
    wait_done(lat, bc);
    tests++; if (lo !== 32'd25) begin fails++; $display("FAIL start_mt_result: got %h want 00000019", lo); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0;
    mthi = 1'b0; mtlo = 1'b0; hi_lo_wdata = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div0();
    test_ignore_start();
    test_reset_mid();
    test_mt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
